// File: rtl/add_if.sv
// Operand/result bundle for the add functional unit.
//
// Handshake: the unit has no ready; it accepts one operation on every rising
// edge where stall is 0. in_valid qualifies in0/in1/cin on that edge, and
// out_valid qualifies out/cout/overflow. While stall is 1 nothing is sampled
// and every result output holds its value.
interface add_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             in_valid;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             cin;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             overflow;
  logic             out_valid;

  modport master (
    output stall, in_valid, in0, in1, cin,
    input  out, cout, overflow, out_valid
  );

  modport slave (
    input  stall, in_valid, in0, in1, cin,
    output out, cout, overflow, out_valid
  );
endinterface

// File: rtl/add.sv
// Fixed-latency integer adder: {cout, out} = in0 + in1 + cin with signed
// overflow flag. STAGES = 0 is purely combinational; otherwise the result is
// computed into stage 1 and shifted through STAGES registers, frozen by stall.
module add #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  add_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("add: WIDTH=%0d is outside 1..64", WIDTH);
  end
  if (STAGES < 0 || STAGES > 4) begin : g_bad_stages
    $error("add: STAGES=%0d is outside 0..4", STAGES);
  end

  logic [WIDTH:0]   full_sum;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  // Full-width sum of zero-extended operands; bit WIDTH is the carry-out.
  always_comb begin
    full_sum = {1'b0, bus.in0} + {1'b0, bus.in1} + {{WIDTH{1'b0}}, bus.cin};
    sum_c    = full_sum[WIDTH-1:0];
    cout_c   = full_sum[WIDTH];
    ovf_c    = (bus.in0[WIDTH-1] == bus.in1[WIDTH-1]) &&
               (sum_c[WIDTH-1] != bus.in0[WIDTH-1]);
  end

  if (STAGES == 0) begin : g_comb
    // Clock, reset and stall have no role without registers.
    logic unused_ctrl;
    assign unused_ctrl   = &{1'b0, clk, rst, bus.stall};
    assign bus.out       = sum_c;
    assign bus.cout      = cout_c;
    assign bus.overflow  = ovf_c;
    assign bus.out_valid = bus.in_valid;
  end else begin : g_pipe
    typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
    } stage_t;

    stage_t stage_q [STAGES];
    stage_t stage_d [STAGES];

    // Next chain state: hold everything on stall, else load stage 1 and shift.
    always_comb begin
      stage_d = stage_q;
      if (!bus.stall) begin
        stage_d[0].valid = bus.in_valid;
        stage_d[0].sum   = sum_c;
        stage_d[0].cout  = cout_c;
        stage_d[0].ovf   = ovf_c;
        for (int i = 1; i < STAGES; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    // Stage registers; reset clears in-flight results immediately.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < STAGES; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < STAGES; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign bus.out       = stage_q[STAGES-1].sum;
    assign bus.cout      = stage_q[STAGES-1].cout;
    assign bus.overflow  = stage_q[STAGES-1].ovf;
    assign bus.out_valid = stage_q[STAGES-1].valid;
  end

endmodule

// File: tb/tb_add.sv
// Bench for add: several width/latency configurations share one stimulus
// stream; directed scenarios plus a randomized run against a delay-queue model.
module tb_add;

  localparam int N = 8;

  function automatic int w_of(int k);
    case (k)
      0, 1, 2, 3: return 32;
      4:          return 1;
      5, 7:       return 8;
      default:    return 64;
    endcase
  endfunction

  function automatic int s_of(int k);
    case (k)
      0:       return 0;
      1:       return 1;
      2:       return 2;
      3:       return 3;
      4:       return 4;
      5:       return 0;
      6:       return 4;
      default: return 2;
    endcase
  endfunction

  typedef struct packed {
    logic        v;
    logic        ovf;
    logic        co;
    logic [63:0] s;
  } res_t;

  typedef struct packed {
    logic        v;
    logic        c;
    logic [63:0] a;
    logic [63:0] b;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        s_stall;
  logic        s_valid;
  logic        s_cin;
  logic [63:0] s_in0;
  logic [63:0] s_in1;

  always #5 clk = ~clk;

  res_t obs [N];
  int   tests = 0;
  int   fails = 0;

  for (genvar k = 0; k < N; k++) begin : g
    add_if #(.WIDTH(w_of(k))) bus ();
    assign bus.stall    = s_stall;
    assign bus.in_valid = s_valid;
    assign bus.cin      = s_cin;
    assign bus.in0      = s_in0[w_of(k)-1:0];
    assign bus.in1      = s_in1[w_of(k)-1:0];
    add #(.WIDTH(w_of(k)), .STAGES(s_of(k))) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign obs[k] = {bus.out_valid, bus.overflow, bus.cout, 64'(bus.out)};
  end

  // ---------------- reference model ----------------
  // Inputs accepted on non-stalled edges since the last reset, newest last.
  vec_t hist[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
    end else if (!s_stall) begin
      hist.push_back('{v: s_valid, c: s_cin, a: s_in0, b: s_in1});
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  // Arithmetic result of one operation at width w, from integer arithmetic.
  function automatic res_t calc(int w, vec_t x);
    logic [63:0]        mask, am, bm;
    logic [64:0]        full;
    logic signed [65:0] sa, sb, ss, lim;
    res_t r;
    mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am    = x.a & mask;
    bm    = x.b & mask;
    full  = {1'b0, am} + {1'b0, bm} + {64'd0, x.c};
    r.v   = x.v;
    r.s   = full[63:0] & mask;
    r.co  = full[w];
    lim   = 66'sd1 <<< (w - 1);
    sa    = $signed({2'b00, am});
    if (am[w-1]) sa = sa - (lim <<< 1);
    sb    = $signed({2'b00, bm});
    if (bm[w-1]) sb = sb - (lim <<< 1);
    ss    = sa + sb + $signed({65'd0, x.c});
    r.ovf = (ss >= lim) || (ss < -lim);
    return r;
  endfunction

  // Expected outputs of DUT k: the input accepted s_of(k) edges ago.
  function automatic res_t model(int k);
    int s;
    s = s_of(k);
    if (s == 0) return calc(w_of(k), '{v: s_valid, c: s_cin, a: s_in0, b: s_in1});
    if (hist.size() >= s) return calc(w_of(k), hist[hist.size() - s]);
    return '0;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic st);
    s_valid = v;
    s_in0   = a;
    s_in1   = b;
    s_cin   = c;
    s_stall = st;
  endtask

  task automatic flush();
    repeat (6) begin
      @(negedge clk);
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return {64{1'b1}};
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'(($urandom_range(0, 15)));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      tests++;
      if (obs[k] !== '0) begin
        $display("FAIL reset dut%0d: got %h, expected 0", k, obs[k]);
        fails++;
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [63:0] a_t [3];
    logic [63:0] b_t [3];
    res_t        e_t [3];
    a_t = '{64'd5, 64'hFFFF_FFFF, 64'h7FFF_FFFF};
    b_t = '{64'd7, 64'd1, 64'd1};
    e_t[0] = '{v: 1'b1, ovf: 1'b0, co: 1'b0, s: 64'd12};
    e_t[1] = '{v: 1'b1, ovf: 1'b0, co: 1'b1, s: 64'd0};
    e_t[2] = '{v: 1'b1, ovf: 1'b1, co: 1'b0, s: 64'h8000_0000};
    flush();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) drive(1'b1, a_t[i], b_t[i], 1'b0, 1'b0);
      else       drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      #1;
      if (i > 0) begin
        tests++;
        if (obs[1] !== e_t[i-1]) begin
          $display("FAIL basic op%0d: got v=%b s=%h co=%b ov=%b, expected v=%b s=%h co=%b ov=%b",
                   i - 1, obs[1].v, obs[1].s, obs[1].co, obs[1].ovf,
                   e_t[i-1].v, e_t[i-1].s, e_t[i-1].co, e_t[i-1].ovf);
          fails++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    flush();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 3) drive(1'b1, 64'(c + 1), 64'(c + 1), 1'b0, 1'b0);
      else       drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      #1;
      exp_v = (c >= 3 && c <= 5);
      tests++;
      if (obs[3].v !== exp_v || (exp_v && obs[3].s !== 64'(2 * (c - 2)))) begin
        $display("FAIL back_to_back cycle%0d: got v=%b s=%0d, expected v=%b s=%0d",
                 c, obs[3].v, obs[3].s, exp_v, 2 * (c - 2));
        fails++;
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    res_t        snap;
    logic        prev_stall;
    logic        st;
    int          ptr;
    flush();
    exp_q      = {64'd2, 64'd4, 64'd6, 64'd8};
    ptr        = 0;
    prev_stall = 1'b0;
    snap       = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      st = (c == 3 || c == 4);
      if (st) drive(1'b1, 64'd99, 64'd99, 1'b0, 1'b1);
      else if (ptr < 4) begin
        drive(1'b1, 64'(ptr + 1), 64'(ptr + 1), 1'b0, 1'b0);
        ptr++;
      end else drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      #1;
      if (c == 3) snap = obs[3];
      if (c == 4 || c == 5) begin
        tests++;
        if (obs[3] !== snap) begin
          $display("FAIL stall_hold cycle%0d: got %h, expected %h", c, obs[3], snap);
          fails++;
        end
      end
      if (!prev_stall && obs[3].v) got_q.push_back(obs[3].s);
      prev_stall = st;
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      $display("FAIL stall_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
      fails++;
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin
          $display("FAIL stall_order #%0d: got %0d, expected %0d", i, got_q[i], exp_q[i]);
          fails++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    flush();
    @(negedge clk);
    drive(1'b1, 64'd3, 64'd4, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 64'd5, 64'd6, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    #1;
    tests++;
    if (obs[2].v !== 1'b1 || obs[2].s !== 64'd7) begin
      $display("FAIL reset_mid_pre: got v=%b s=%0d, expected v=1 s=7", obs[2].v, obs[2].s);
      fails++;
    end
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      if (s_of(k) > 0) begin
        tests++;
        if (obs[k] !== '0) begin
          $display("FAIL reset_mid_async dut%0d: got %h, expected 0", k, obs[k]);
          fails++;
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (s_of(k) > 0) begin
          tests++;
          if (obs[k].v !== 1'b0) begin
            $display("FAIL reset_mid_stale dut%0d cycle%0d: got v=%b s=%h, expected v=0",
                     k, c, obs[k].v, obs[k].s);
            fails++;
          end
        end
      end
    end
  endtask

  task automatic test_comb();
    res_t e;
    e = '{v: 1'b1, ovf: 1'b0, co: 1'b0, s: 64'h31};
    @(negedge clk);
    drive(1'b1, 64'h10, 64'h20, 1'b1, 1'b0);
    #1;
    tests++;
    if (obs[0] !== e) begin
      $display("FAIL comb_w32: got %h, expected %h", obs[0], e);
      fails++;
    end
    tests++;
    if (obs[5] !== e) begin
      $display("FAIL comb_w8: got %h, expected %h", obs[5], e);
      fails++;
    end
    #1;
    s_valid = 1'b0;
    #1;
    tests++;
    if (obs[0].v !== 1'b0) begin
      $display("FAIL comb_valid: got %b, expected 0", obs[0].v);
      fails++;
    end
  endtask

  task automatic test_width1();
    logic [2:0] jb;
    logic       a, b, ci, es, ec, eo;
    flush();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      jb = 3'(c);
      if (c < 8) drive(1'b1, {63'd0, jb[2]}, {63'd0, jb[1]}, jb[0], 1'b0);
      else       drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      #1;
      if (c >= 4) begin
        jb = 3'(c - 4);
        a  = jb[2];
        b  = jb[1];
        ci = jb[0];
        es = a ^ b ^ ci;
        ec = (a & b) | (a & ci) | (b & ci);
        eo = (a == b) && (es != a);
        tests++;
        if (obs[4] !== '{v: 1'b1, ovf: eo, co: ec, s: {63'd0, es}}) begin
          $display("FAIL width1 a=%b b=%b c=%b: got v=%b s=%0d co=%b ov=%b, expected v=1 s=%0d co=%b ov=%b",
                   a, b, ci, obs[4].v, obs[4].s, obs[4].co, obs[4].ovf, es, ec, eo);
          fails++;
        end
      end
    end
  endtask

  task automatic test_random();
    res_t e;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 4) == 0);
      #1;
      for (int k = 0; k < N; k++) begin
        e = model(k);
        tests++;
        if (obs[k] !== e) begin
          $display("FAIL random n=%0d dut%0d (W=%0d S=%0d): got v=%b s=%h co=%b ov=%b, expected v=%b s=%h co=%b ov=%b",
                   n, k, w_of(k), s_of(k), obs[k].v, obs[k].s, obs[k].co, obs[k].ovf,
                   e.v, e.s, e.co, e.ovf);
          fails++;
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_comb();
    test_width1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
